jesd_loop_checker: RTL and testbench
====================================

# jesd_loop_checker

Parametrised JESD204 loopback traffic generator and checker for the ZC706 JESD loop test design. Drives a ramp or per-lane PRBS-15 pattern into the JESD TX AXI-stream port and verifies the RX AXI-stream stream returned by the loop. Verification is self-synchronising: no fixed latency is assumed. It reports lock, error and word counts, plus a 4-bit LED status.

## Interface
Parameters:
- LANES, 2: number of 16-bit sample lanes (1..8); data width DW = 16*LANES.
- LOCK_CNT, 16: consecutive matching RX beats required for lock.
- TIMEOUT, 1024: cycles allowed in ACQUIRE before FAIL.
- ERR_W, 16: error counter width.
- HB_W, 24: heartbeat counter width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- trig_in  in  1  asynchronous start request; rising edge (re)starts a test.
- mode  in  1  0 = ramp, 1 = PRBS-15; sampled only on start.
- tx_tdata  out  DW  pattern to JESD TX.
- tx_tready  in  1  TX core accepts the current word.
- rx_tdata  in  DW  data from JESD RX.
- rx_tvalid  in  1  RX beat valid.
- state  out  2  0 IDLE, 1 ACQUIRE, 2 LOCKED, 3 FAIL.
- err_cnt  out  ERR_W  saturating mismatch count in LOCKED.
- word_cnt  out  32  saturating checked-beat count in LOCKED.
- led  out  4  {fail_or_err, locked_clean, running, heartbeat}.

## Operation
- Lane i occupies bits [16i+15:16i].
- **Ramp pattern:** next lane word = current + LANES (mod 2^16). Seed for lane i is i.
- **PRBS pattern:** serial sequence s[j] = s[j-15] ^ s[j-14]. Each word holds 16 consecutive bits, with the oldest bit at bit 15. The next word is a pure function of the current 16-bit word. Seed for lane i is 16'hACE1 + i.
- **trig_in synchronisation:** 2-FF synchroniser, then a third flop. start = s2 & ~s3.
- **start, from any state:**
  - state goes to ACQUIRE.
  - TX generator loads the seed.
  - Cleared: err_cnt, word_cnt, match_run, timer, have_prev.
  - mode is latched.
- **TX:**
  - In IDLE, tx_tdata = 0.
  - Otherwise it holds the current word and advances at an edge with tx_tready = 1.
- **Checker:**
  - On each rx_tvalid beat, expected = next(prev). prev is the last valid RX word, and have_prev gets set.
  - The first beat after start is not compared.
- **ACQUIRE:**
  - Matching beat: match_run++.
  - Mismatch: match_run = 0; no error counted.
  - match_run reaching LOCK_CNT moves to LOCKED.
  - timer counts every cycle; at timer == TIMEOUT-1 without lock, move to FAIL.
- **LOCKED:**
  - Every compared beat increments word_cnt.
  - A mismatch increments err_cnt.
  - Both counters saturate at all-ones.
  - state stays LOCKED.
- **FAIL:** sticky until the next start.
- **LEDs:**
  - led[0] = bit HB_W-1 of a free-running counter.
  - led[1] = ACQUIRE or LOCKED.
  - led[2] = LOCKED and err_cnt == 0.
  - led[3] = FAIL or err_cnt != 0.
- **Simultaneous events:**
  - start beats everything; a coincident RX beat is discarded.
  - Lock beats timeout in the same cycle.
  - A single corrupted RX word yields exactly 2 errors: the bad word, and the next word checked against it.

## Timing
- **Reset values:** tx_tdata 0, state 0, err_cnt 0, word_cnt 0, led 4'b0000, all internal registers 0.
- **Asynchronous reset:** takes effect immediately, including mid-test.
- **Start latency:** trig_in high before edge 1 gives state = ACQUIRE after edge 3. The first seed word is on tx_tdata at the same time.
- **Counter updates:** err_cnt, word_cnt and state update at the edge that samples the RX beat (0-cycle registered latency). led follows one cycle later (registered).
- **Lock timing:** with continuous rx_tvalid and a clean stream, LOCKED is reached at the edge sampling the (LOCK_CNT+1)th beat.

## Configuration
- Macro: JESD_LOOP_ERR_INJ_EN.
- **Defined:**
  - Adds input port inj_err (1 bit).
  - A rising edge of inj_err arms a one-shot. The next TX word accepted with tx_tready = 1 has bit 0 of lane 0 inverted.
  - The generator state is unaffected.
  - The one-shot then clears.
- **Undefined:** the port and logic are absent; TX is always the clean pattern.

## Test plan
- **Ramp lock:** LANES=2, mode=0, rx = tx_tdata delayed 5 cycles, rx_tvalid = 1, tx_tready = 1, trig pulse -> LOCKED after 17 beats, err_cnt = 0, led[3:1] = 3'b011.
- **PRBS lock:** same setup with mode=1 -> LOCKED, err_cnt = 0. First TX word is {16'hACE2, 16'hACE1}.
- **Single corruption:** in LOCKED, flip bit 7 of one RX word -> err_cnt = 2 and led[3] = 1. word_cnt keeps incrementing.
- **Timeout:** TIMEOUT=64, rx_tvalid held 0 -> state = FAIL exactly 64 cycles after entering ACQUIRE; led[1] = 0, led[3] = 1. A new trig returns to ACQUIRE.
- **Backpressure and reset:**
  - Toggle tx_tready 50% -> tx_tdata holds while low, lock is still achieved, err_cnt = 0.
  - Assert rst mid-LOCKED -> every output is 0 immediately.
- **Error injection (JESD_LOOP_ERR_INJ_EN):** pulse inj_err while LOCKED -> err_cnt = 2. TX resumes the clean pattern on the following word.

Source files
------------

// File: rtl/jesd_loop_if.sv
// jesd_loop_if: TX/RX AXI-stream bundle between the loop checker and the JESD
// link. The checker is the master: it drives tx_tdata and receives rx_tdata.
interface jesd_loop_if #(
  parameter int LANES = 2
) ();
  localparam int DW = 16 * LANES;

  logic [DW-1:0] tx_tdata;
  logic          tx_tready;
  logic [DW-1:0] rx_tdata;
  logic          rx_tvalid;

  modport master (
    output tx_tdata,
    input  tx_tready,
    input  rx_tdata,
    input  rx_tvalid
  );

  modport slave (
    input  tx_tdata,
    output tx_tready,
    output rx_tdata,
    output rx_tvalid
  );
endinterface

// File: rtl/jesd_loop_checker.sv
// jesd_loop_checker: ramp / PRBS-15 traffic generator for the JESD TX stream
// and a self-synchronising checker for the looped-back RX stream.
// Optional feature macro: JESD_LOOP_ERR_INJ_EN adds the inj_err input, which
// flips bit 0 of lane 0 on one accepted TX word.
module jesd_loop_checker #(
  parameter int LANES    = 2,
  parameter int LOCK_CNT = 16,
  parameter int TIMEOUT  = 1024,
  parameter int ERR_W    = 16,
  parameter int HB_W     = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig_in,
  input  logic             mode,
`ifdef JESD_LOOP_ERR_INJ_EN
  input  logic             inj_err,
`endif
  jesd_loop_if.master      bus,
  output logic [1:0]       state,
  output logic [ERR_W-1:0] err_cnt,
  output logic [31:0]      word_cnt,
  output logic [3:0]       led
);

  localparam int DW   = 16 * LANES;
  localparam int MR_W = $clog2(LOCK_CNT + 1);
  localparam int TM_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAIL    = 2'd3
  } state_e;

  // One PRBS-15 word step: 16 serial bits, oldest at bit 15.
  function automatic logic [15:0] prbs_next(input logic [15:0] w);
    logic [31:0] b;
    logic [15:0] r;
    b = '0;
    for (int n = 0; n < 16; n++) b[n] = w[15-n];
    for (int n = 16; n < 32; n++) b[n] = b[n-15] ^ b[n-14];
    for (int m = 0; m < 16; m++) r[15-m] = b[16+m];
    return r;
  endfunction

  function automatic logic [DW-1:0] next_word(input logic [DW-1:0] w, input logic m);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++)
      r[16*i +: 16] = m ? prbs_next(w[16*i +: 16]) : w[16*i +: 16] + 16'(LANES);
    return r;
  endfunction

  function automatic logic [DW-1:0] seed_word(input logic m);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++)
      r[16*i +: 16] = m ? 16'hACE1 + 16'(i) : 16'(i);
    return r;
  endfunction

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [DW-1:0]    gen_q, gen_d;
  logic [DW-1:0]    prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic [MR_W-1:0]  match_run_q, match_run_d;
  logic [TM_W-1:0]  timer_q, timer_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]      word_cnt_q, word_cnt_d;
  logic [HB_W-1:0]  hb_q, hb_d;
  logic [3:0]       led_q, led_d;
  logic             trig_s1_q, trig_s2_q, trig_s3_q;
  logic             inj_arm_q, inj_arm_d;
  logic             start, compared, match;
  logic [DW-1:0]    inj_mask;

`ifdef JESD_LOOP_ERR_INJ_EN
  logic inj_prev_q;
`endif

  assign start    = trig_s2_q & ~trig_s3_q;
  assign compared = bus.rx_tvalid & have_prev_q;
  assign match    = compared && (bus.rx_tdata == next_word(prev_q, mode_q));
  assign inj_mask = {{(DW-1){1'b0}}, inj_arm_q};

  // Next-state logic for the FSM, generator, checker and status counters.
  always_comb begin
    // NOTE: every _d takes its _q value first, so no path through this block
    // can leave a signal unassigned and infer a latch.
    state_d     = state_q;
    mode_d      = mode_q;
    gen_d       = gen_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    match_run_d = match_run_q;
    timer_d     = timer_q;
    err_cnt_d   = err_cnt_q;
    word_cnt_d  = word_cnt_q;
    hb_d        = hb_q + 1'b1;
    led_d       = {(state_q == ST_FAIL) || (err_cnt_q != '0),
                   (state_q == ST_LOCKED) && (err_cnt_q == '0),
                   (state_q == ST_ACQUIRE) || (state_q == ST_LOCKED),
                   hb_q[HB_W-1]};

    // The one-shot clears once its corrupted word is accepted; a new rising
    // edge in the same cycle re-arms it for the following word.
    inj_arm_d = inj_arm_q;
    if (state_q != ST_IDLE && bus.tx_tready) inj_arm_d = 1'b0;
`ifdef JESD_LOOP_ERR_INJ_EN
    if (inj_err && !inj_prev_q) inj_arm_d = 1'b1;
`endif

    if (start) begin
      // Restart wins over everything, including a coincident RX beat.
      state_d     = ST_ACQUIRE;
      mode_d      = mode;
      gen_d       = seed_word(mode);
      have_prev_d = 1'b0;
      match_run_d = '0;
      timer_d     = '0;
      err_cnt_d   = '0;
      word_cnt_d  = '0;
    end else begin
      if (state_q != ST_IDLE && bus.tx_tready) gen_d = next_word(gen_q, mode_q);
      if (bus.rx_tvalid) begin
        prev_d      = bus.rx_tdata;
        have_prev_d = 1'b1;
      end
      case (state_q)
        ST_ACQUIRE: begin
          timer_d = timer_q + 1'b1;
          if (compared) match_run_d = match ? match_run_q + 1'b1 : '0;
          // Lock takes priority over a timeout landing on the same edge.
          if (match && match_run_q == MR_W'(LOCK_CNT - 1))
            state_d = ST_LOCKED;
          else if (timer_q == TM_W'(TIMEOUT - 1))
            state_d = ST_FAIL;
        end
        ST_LOCKED: begin
          if (compared) begin
            if (!(&word_cnt_q)) word_cnt_d = word_cnt_q + 1'b1;
            if (!match && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // All state registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      gen_q       <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      match_run_q <= '0;
      timer_q     <= '0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
      hb_q        <= '0;
      led_q       <= '0;
      trig_s1_q   <= 1'b0;
      trig_s2_q   <= 1'b0;
      trig_s3_q   <= 1'b0;
      inj_arm_q   <= 1'b0;
`ifdef JESD_LOOP_ERR_INJ_EN
      inj_prev_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      mode_q      <= mode_d;
      gen_q       <= gen_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      match_run_q <= match_run_d;
      timer_q     <= timer_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
      hb_q        <= hb_d;
      led_q       <= led_d;
      trig_s1_q   <= trig_in;
      trig_s2_q   <= trig_s1_q;
      trig_s3_q   <= trig_s2_q;
      inj_arm_q   <= inj_arm_d;
`ifdef JESD_LOOP_ERR_INJ_EN
      inj_prev_q  <= inj_err;
`endif
    end
  end

  assign bus.tx_tdata = (state_q == ST_IDLE) ? '0 : (gen_q ^ inj_mask);
  assign state        = state_q;
  assign err_cnt      = err_cnt_q;
  assign word_cnt     = word_cnt_q;
  assign led          = led_q;

endmodule

// File: tb/tb_jesd_loop_checker.sv
// tb_jesd_loop_checker: directed bench for jesd_loop_checker (LANES=2,
// LOCK_CNT=16, TIMEOUT=64). RX comes either from a 5-stage loopback of TX
// (valid = accepted) or from directly driven vectors.
module tb_jesd_loop_checker;

  localparam int LANES   = 2;
  localparam int DW      = 16 * LANES;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig_in;
  logic        mode;
  logic        tready;
  logic [1:0]  state;
  logic [15:0] err_cnt;
  logic [31:0] word_cnt;
  logic [3:0]  led;
`ifdef JESD_LOOP_ERR_INJ_EN
  logic        inj_err;
`endif

  jesd_loop_if #(.LANES(LANES)) bus ();

  jesd_loop_checker #(
    .LANES(LANES), .LOCK_CNT(16), .TIMEOUT(TIMEOUT), .ERR_W(16), .HB_W(24)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .trig_in  (trig_in),
    .mode     (mode),
`ifdef JESD_LOOP_ERR_INJ_EN
    .inj_err  (inj_err),
`endif
    .bus      (bus),
    .state    (state),
    .err_cnt  (err_cnt),
    .word_cnt (word_cnt),
    .led      (led)
  );

  always #5 clk = ~clk;

  // Loopback path: five register stages, valid only for accepted words.
  logic [DW-1:0] pipe_d [5];
  logic          pipe_v [5];
  logic          loop_en;
  logic [DW-1:0] drv_data;
  logic          drv_valid;
  logic [DW-1:0] flip;

  always @(posedge clk) begin
    pipe_d[0] <= bus.tx_tdata;
    pipe_v[0] <= tready;
    for (int i = 1; i < 5; i++) begin
      pipe_d[i] <= pipe_d[i-1];
      pipe_v[i] <= pipe_v[i-1];
    end
  end

  assign bus.tx_tready = tready;
  assign bus.rx_tdata  = loop_en ? (pipe_d[4] ^ flip) : drv_data;
  assign bus.rx_tvalid = loop_en ? pipe_v[4] : drv_valid;

  int n_vec = 0;
  int n_bad = 0;
  int since_lock = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      since_lock++;
    end
  endtask

  task automatic do_start(input logic m);
    mode    = m;
    trig_in = 1'b1;
    tick();
    tick();
    tick();
    trig_in = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] tgt, input int budget, input string tag);
    for (int i = 0; i < budget && state !== tgt; i++) tick();
    check(tag, state, tgt);
    since_lock = 0;
  endtask

  task automatic beat(input logic [DW-1:0] d);
    drv_valid = 1'b1;
    drv_data  = d;
    tick();
  endtask

  // Ramp word j of the post-discontinuity run used in the direct lock test.
  function automatic logic [DW-1:0] rw(input int j);
    return {16'h4001 + 16'(2 * j), 16'h4000 + 16'(2 * j)};
  endfunction

  logic [DW-1:0] exp_tx;

  initial begin
    rst = 1'b0; trig_in = 1'b0; mode = 1'b0; tready = 1'b1;
    loop_en = 1'b0; drv_data = '0; drv_valid = 1'b0; flip = '0;
`ifdef JESD_LOOP_ERR_INJ_EN
    inj_err = 1'b0;
`endif
    #2 rst = 1'b1;
    #2;
    check("rst_state", state, 2'd0);
    check("rst_tx", bus.tx_tdata, 32'h0);
    check("rst_err", err_cnt, 16'd0);
    check("rst_words", word_cnt, 32'd0);
    check("rst_led", led, 4'b0000);
    tick();
    rst = 1'b0;
    tick();

    // Start latency: trig high before edge 1, ACQUIRE after edge 3.
    trig_in = 1'b1;
    tick();
    check("lat_e1", state, 2'd0);
    tick();
    check("lat_e2", state, 2'd0);
    tick();
    trig_in = 1'b0;
    check("lat_e3", state, 2'd1);
    check("lat_seed", bus.tx_tdata, 32'h0001_0000);

    // Direct ramp: 9 clean beats, a discontinuity, then 16 matches to lock.
    for (int k = 0; k < 9; k++) beat({16'(2 * k + 1), 16'(2 * k)});
    for (int j = 0; j < 16; j++) beat(rw(j));
    check("dir_acq", state, 2'd1);
    check("dir_acq_err", err_cnt, 16'd0);
    beat(rw(16));
    check("dir_lock", state, 2'd2);
    check("dir_lock_words", word_cnt, 32'd0);
    beat(rw(17));
    beat(rw(18) ^ 32'h0000_0080);
    check("dir_bad_err", err_cnt, 16'd1);
    beat(rw(19));
    beat(rw(20));
    check("dir_err2", err_cnt, 16'd2);
    check("dir_words", word_cnt, 32'd4);
    drv_valid = 1'b0;
    tick();
    check("dir_led", led[3:1], 3'b101);

    // Ramp through the loopback.
    loop_en = 1'b1;
    do_start(1'b0);
    check("ramp_seed", bus.tx_tdata, 32'h0001_0000);
    wait_state(2'd2, 60, "ramp_lock");
    run(30);
    check("ramp_err", err_cnt, 16'd0);
    check("ramp_words", word_cnt, 32'(since_lock));
    check("ramp_led", led[3:1], 3'b011);

    // PRBS through the loopback, then one corrupted RX word.
    do_start(1'b1);
    check("prbs_seed", bus.tx_tdata, 32'hACE2_ACE1);
    tick();
    check("prbs_word1", bus.tx_tdata, 32'hEA4E_EA44);
    wait_state(2'd2, 60, "prbs_lock");
    run(10);
    check("prbs_err0", err_cnt, 16'd0);
    flip = 32'h0000_0080;
    run(1);
    flip = '0;
    run(5);
    check("prbs_err2", err_cnt, 16'd2);
    check("prbs_led3", led[3], 1'b1);
    check("prbs_words", word_cnt, 32'(since_lock));

    // Backpressure: ramp with tx_tready toggling every cycle.
    do_start(1'b0);
    exp_tx = 32'h0001_0000;
    for (int i = 0; i < 60; i++) begin
      tready = i[0];
      if (i < 12) check("bp_tx", bus.tx_tdata, exp_tx);
      tick();
      if (tready) exp_tx = {exp_tx[31:16] + 16'd2, exp_tx[15:0] + 16'd2};
    end
    tready = 1'b1;
    check("bp_lock", state, 2'd2);
    check("bp_err", err_cnt, 16'd0);

    // Asynchronous reset in the middle of LOCKED.
    #3 rst = 1'b1;
    #1;
    check("arst_state", state, 2'd0);
    check("arst_tx", bus.tx_tdata, 32'h0);
    check("arst_words", word_cnt, 32'd0);
    check("arst_led", led, 4'b0000);
    tick();
    rst = 1'b0;
    tick();

`ifdef JESD_LOOP_ERR_INJ_EN
    // Error injection on one accepted TX word.
    do_start(1'b0);
    wait_state(2'd2, 60, "inj_lock");
    run(5);
    inj_err = 1'b1;
    tick();
    inj_err = 1'b0;
    run(15);
    check("inj_err2", err_cnt, 16'd2);
    check("inj_state", state, 2'd2);
    tick();
`endif

    // Timeout with no RX traffic: FAIL 64 cycles after entering ACQUIRE.
    loop_en   = 1'b0;
    drv_valid = 1'b0;
    do_start(1'b0);
    check("to_acq", state, 2'd1);
    run(TIMEOUT - 1);
    check("to_edge63", state, 2'd1);
    tick();
    check("to_fail", state, 2'd3);
    tick();
    check("to_led", led[3:1], 3'b100);
    run(3);
    check("to_sticky", state, 2'd3);
    do_start(1'b0);
    check("to_restart", state, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
